// File: rtl/result_buf_pkg.sv
// Shared types and default sizes for the result buffer.
package result_buf_pkg;

   localparam int RB_DATA_W = 32;
   localparam int RB_ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } rb_state_t;

endpackage

// File: rtl/rb_dp_ram.sv
// Result storage. Port A serves the write pipeline (old-word read, commit/clear write),
// port B is the host read-only port. Read data is unregistered.
module rb_dp_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_waddr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [ADDR_W-1:0] a_raddr,
   output logic [DATA_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (a_we) mem[a_waddr] <= a_wdata;
   end

   assign a_rdata = mem[a_raddr];
   assign b_rdata = mem[b_addr];

endmodule

// File: rtl/result_buffer.sv
// Accumulating result buffer: 3-stage write/accumulate pipeline, 1-cycle host reads and a
// drain-then-zero-fill clear FSM. Define RESULT_BUF_SAT_EN for saturating accumulate + sticky ovf.
module result_buffer
   import result_buf_pkg::*;
#(
   parameter int DATA_W = RB_DATA_W,
   parameter int ADDR_W = RB_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_acc,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              clr_start,
   output logic              busy,
   output logic              ovf
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   rb_state_t         state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              accept;
   logic              clr_accept;

   logic              s1_vld;
   logic              s1_acc;
   logic [ADDR_W-1:0] s1_addr;
   logic [DATA_W-1:0] s1_data;
   logic [DATA_W-1:0] s1_old;
   logic [DATA_W-1:0] s1_res;
   logic              s2_vld;
   logic [ADDR_W-1:0] s2_addr;
   logic [DATA_W-1:0] s2_data;

   logic [DATA_W-1:0] old_fwd;
   logic [DATA_W-1:0] ram_a_q;
   logic [DATA_W-1:0] ram_b_q;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   assign accept     = wr_valid & wr_ready;
   assign clr_accept = clr_start & (state == IDLE);

   // S0 old word: the youngest in-flight write to the same address wins over memory
   always_comb begin
      old_fwd = ram_a_q;
      if (s1_vld && s1_addr == wr_addr)      old_fwd = s1_res;
      else if (s2_vld && s2_addr == wr_addr) old_fwd = s2_data;
   end

`ifdef RESULT_BUF_SAT_EN
   logic [DATA_W:0] sum_ext;
   logic            s1_sat;

   always_comb begin
      sum_ext = {s1_old[DATA_W-1], s1_old} + {s1_data[DATA_W-1], s1_data};
      s1_sat  = 1'b0;
      s1_res  = s1_acc ? sum_ext[DATA_W-1:0] : s1_data;
      // top two bits of the extended sum disagree only on signed overflow
      if (s1_acc && (sum_ext[DATA_W] != sum_ext[DATA_W-1])) begin
         s1_sat = 1'b1;
         s1_res = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) ovf <= 1'b0;
      else       ovf <= (ovf & ~clr_accept) | (s1_vld & s1_sat);
   end
`else
   always_comb begin
      s1_res = s1_acc ? (s1_old + s1_data) : s1_data;
   end

   assign ovf = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end else begin
         s1_vld <= accept;
         s2_vld <= s1_vld;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         s1_addr <= wr_addr;
         s1_data <= wr_data;
         s1_acc  <= wr_acc;
         s1_old  <= old_fwd;
      end
      if (s1_vld) begin
         s2_addr <= s1_addr;
         s2_data <= s1_res;
      end
   end

   // Commit happens at the end of S1 so the word is in memory once it reaches S2.
   // Reset suppresses the write so in-flight work is abandoned.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = s1_addr;
      ram_wdata = s1_res;
      if (state == CLEAR) begin
         ram_we    = ~reset;
         ram_waddr = clr_cnt;
         ram_wdata = '0;
      end else if (s1_vld) begin
         ram_we = ~reset;
      end
   end

   rb_dp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock   (clock),
      .a_we    (ram_we),
      .a_waddr (ram_waddr),
      .a_wdata (ram_wdata),
      .a_raddr (wr_addr),
      .a_rdata (ram_a_q),
      .b_addr  (rd_addr),
      .b_rdata (ram_b_q)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= ram_b_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         busy     <= 1'b0;
         wr_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clr_accept) begin
                  state    <= DRAIN;
                  clr_cnt  <= '0;
                  busy     <= 1'b1;
                  wr_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (!s1_vld && !s2_vld) state <= CLEAR;
            end
            CLEAR: begin
               if (clr_cnt == LAST_ADDR) begin
                  state    <= IDLE;
                  clr_cnt  <= '0;
                  busy     <= 1'b0;
                  wr_ready <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               clr_cnt  <= '0;
               busy     <= 1'b0;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
